// File: rtl/ez8_pkg.sv
// Shared definitions for the ez8 core: opcodes, destination select, flag positions
// and the execute-stage instruction register layout.
package ez8_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_MOV   = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_INC   = 4'h7;
  localparam logic [3:0] OP_DEC   = 4'h8;
  localparam logic [3:0] OP_MOVI  = 4'h9;
  localparam logic [3:0] OP_ADDI  = 4'hA;
  localparam logic [3:0] OP_STORE = 4'hB;
  localparam logic [3:0] OP_BTSS  = 4'hC;
  localparam logic [3:0] OP_BTSC  = 4'hD;
  localparam logic [3:0] OP_ADDC  = 4'hE;
  localparam logic [3:0] OP_RSVD  = 4'hF;

  localparam logic DEST_ACCUM = 1'b0;
  localparam logic DEST_MEM   = 1'b1;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;

  typedef struct packed {
    logic [3:0] opcode;
    logic [7:0] addr;
    logic [7:0] imm;
    logic       dest;
  } e_reg_t;

  function automatic logic is_skip_op(input logic [3:0] op);
    return (op == OP_BTSS) || (op == OP_BTSC);
  endfunction

endpackage

// File: rtl/ez8_alu.sv
// Combinational ez8 ALU: computes the result, carry and bit-test skip condition
// from register-file data, accumulator, immediate and incoming carry.
module ez8_alu
  import ez8_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [7:0] rdata,
  input  logic [7:0] accum,
  input  logic [7:0] imm,
  input  logic       cin,
  output logic [7:0] res,
  output logic       c,
  output logic       skip_cond
);

  logic [8:0] sum;
  logic       bit_sel;

  assign bit_sel = rdata[imm[2:0]];

  always_comb begin
    sum       = 9'd0;
    res       = 8'h00;
    c         = 1'b0;
    skip_cond = 1'b0;
    case (opcode)
      OP_MOV: res = rdata;
      OP_ADD: begin
        sum = {1'b0, rdata} + {1'b0, accum};
        res = sum[7:0];
        c   = sum[8];
      end
      OP_SUB: begin
        res = rdata - accum;
        c   = (rdata >= accum);
      end
      OP_AND:   res = rdata & accum;
      OP_OR:    res = rdata | accum;
      OP_XOR:   res = rdata ^ accum;
      OP_INC:   res = rdata + 8'd1;
      OP_DEC:   res = rdata - 8'd1;
      OP_MOVI:  res = imm;
      OP_ADDI: begin
        sum = {1'b0, accum} + {1'b0, imm};
        res = sum[7:0];
        c   = sum[8];
      end
      OP_STORE: res = accum;
      OP_BTSS:  skip_cond = bit_sel;
      OP_BTSC:  skip_cond = ~bit_sel;
      OP_ADDC: begin
        sum = {1'b0, rdata} + {1'b0, accum} + {8'd0, cin};
        res = sum[7:0];
        c   = sum[8];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/exec_stage.sv
// ez8 execute/writeback stage: issues the register-file read in R, then executes
// in E and drives register-file, accumulator and flag writes to the memory controller.
module exec_stage
  import ez8_pkg::*;
#(
  parameter int unsigned RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_opcode,
  input  logic [7:0]          in_addr,
  input  logic [7:0]          in_imm,
  input  logic                in_dest,
  output logic [7:0]          mem_readaddr,
  input  logic [7:0]          mem_readdata,
  input  logic [7:0]          accum,
  input  logic                cin,
  output logic [7:0]          mem_writeaddr,
  output logic [7:0]          mem_writedata,
  output logic                mem_write_en,
  output logic                accum_write,
  output logic                zout,
  output logic                z_write,
  output logic                cout,
  output logic                c_write,
  output logic                skip,
  output logic [RETIRE_W-1:0] retired
);

  e_reg_t              e_q;
  logic                e_valid_q;
  logic [RETIRE_W-1:0] retired_q;

  logic       e_active;
  logic [7:0] alu_res;
  logic       alu_c;
  logic       alu_skip_cond;
  logic       skip_taken;
  logic       wr_acc;
  logic       wr_mem;
  logic [1:0] flag_wr;

  assign in_ready     = ~reset;
  assign mem_readaddr = in_addr;

  // Reset discards whatever sits in E in the same cycle, so nothing leaks out.
  assign e_active = e_valid_q & ~reset;

  ez8_alu u_alu (
    .opcode    (e_q.opcode),
    .rdata     (mem_readdata),
    .accum     (accum),
    .imm       (e_q.imm),
    .cin       (cin),
    .res       (alu_res),
    .c         (alu_c),
    .skip_cond (alu_skip_cond)
  );

  assign skip_taken = e_active & is_skip_op(e_q.opcode) & alu_skip_cond;

  // A taken skip squashes the instruction captured at this edge; a squashed
  // skip never reaches e_valid, so it cannot squash its successor.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid_q <= 1'b0;
      e_q       <= '0;
      retired_q <= '0;
    end else begin
      e_valid_q <= in_valid & ~skip_taken;
      if (in_valid) begin
        e_q.opcode <= in_opcode;
        e_q.addr   <= in_addr;
        e_q.imm    <= in_imm;
        e_q.dest   <= in_dest;
      end
      if (e_valid_q) begin
        retired_q <= retired_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    wr_acc  = 1'b0;
    wr_mem  = 1'b0;
    flag_wr = 2'b00;
    case (e_q.opcode)
      OP_MOV, OP_AND, OP_OR, OP_XOR, OP_INC, OP_DEC: begin
        wr_mem          = (e_q.dest == DEST_MEM);
        wr_acc          = (e_q.dest == DEST_ACCUM);
        flag_wr[FLAG_Z] = 1'b1;
      end
      OP_ADD, OP_SUB, OP_ADDC: begin
        wr_mem          = (e_q.dest == DEST_MEM);
        wr_acc          = (e_q.dest == DEST_ACCUM);
        flag_wr[FLAG_Z] = 1'b1;
        flag_wr[FLAG_C] = 1'b1;
      end
      OP_MOVI: wr_acc = 1'b1;
      OP_ADDI: begin
        wr_acc          = 1'b1;
        flag_wr[FLAG_Z] = 1'b1;
        flag_wr[FLAG_C] = 1'b1;
      end
      OP_STORE: wr_mem = 1'b1;
      default: ;
    endcase
  end

  assign mem_write_en  = e_active & wr_mem;
  assign accum_write   = e_active & wr_acc;
  assign z_write       = e_active & flag_wr[FLAG_Z];
  assign c_write       = e_active & flag_wr[FLAG_C];
  assign skip          = skip_taken;
  assign mem_writeaddr = e_active ? e_q.addr : 8'h00;
  assign mem_writedata = e_active ? alu_res : 8'h00;
  assign zout          = e_active & (alu_res == 8'h00);
  assign cout          = e_active & alu_c;
  assign retired       = retired_q;

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage with a small memory/accumulator/carry model that
// forwards same-cycle writes to the read port.
module tb_exec_stage;
  import ez8_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [7:0]  in_addr;
  logic [7:0]  in_imm;
  logic        in_dest;
  logic [7:0]  mem_readaddr;
  logic [7:0]  mem_readdata;
  logic [7:0]  accum;
  logic        cin;
  logic [7:0]  mem_writeaddr;
  logic [7:0]  mem_writedata;
  logic        mem_write_en;
  logic        accum_write;
  logic        zout;
  logic        z_write;
  logic        cout;
  logic        c_write;
  logic        skip;
  logic [15:0] retired;
  logic [4:0]  stb;

  int checks;
  int errors;

  logic [7:0] mem_m [0:255];

  exec_stage #(.RETIRE_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_addr       (in_addr),
    .in_imm        (in_imm),
    .in_dest       (in_dest),
    .mem_readaddr  (mem_readaddr),
    .mem_readdata  (mem_readdata),
    .accum         (accum),
    .cin           (cin),
    .mem_writeaddr (mem_writeaddr),
    .mem_writedata (mem_writedata),
    .mem_write_en  (mem_write_en),
    .accum_write   (accum_write),
    .zout          (zout),
    .z_write       (z_write),
    .cout          (cout),
    .c_write       (c_write),
    .skip          (skip),
    .retired       (retired)
  );

  assign stb = {mem_write_en, accum_write, z_write, c_write, skip};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream model: register file with write forwarding, accumulator, carry.
  always @(posedge clk) begin
    if (mem_write_en) mem_m[mem_writeaddr] <= mem_writedata;
    if (mem_write_en && (mem_writeaddr == mem_readaddr)) mem_readdata <= mem_writedata;
    else mem_readdata <= mem_m[mem_readaddr];
    if (accum_write) accum <= mem_writedata;
    if (c_write) cin <= cout;
  end

  task automatic issue(input logic [3:0] op, input logic [7:0] addr, input logic [7:0] imm,
                       input logic dest);
    in_valid  = 1'b1;
    in_opcode = op;
    in_addr   = addr;
    in_imm    = imm;
    in_dest   = dest;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_opcode = 4'h0; in_addr = 8'h00; in_imm = 8'h00;
    in_dest = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL reset_ready got %b want 0", in_ready); end
    checks++; if (stb !== 5'b00000) begin errors++;
      $display("FAIL reset_strobes got %b want 00000", stb); end
    checks++; if (retired !== 16'd0) begin errors++;
      $display("FAIL reset_retired got %0d want 0", retired); end
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL release_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    issue(OP_MOVI, 8'h00, 8'hFB, 1'b0);
    checks++; if (stb !== 5'b01000 || mem_writedata !== 8'hFB) begin errors++;
      $display("FAIL movi got stb=%b wd=%h want 01000/fb", stb, mem_writedata); end
    issue(OP_STORE, 8'h20, 8'h00, 1'b1);
    checks++; if (stb !== 5'b10000 || mem_writeaddr !== 8'h20 || mem_writedata !== 8'hFB) begin
      errors++;
      $display("FAIL store got stb=%b wa=%h wd=%h want 10000/20/fb", stb, mem_writeaddr,
               mem_writedata); end
    issue(OP_MOVI, 8'h00, 8'h05, 1'b0);
    issue(OP_ADD, 8'h20, 8'h00, 1'b0);
    checks++; if (stb !== 5'b01110) begin errors++;
      $display("FAIL add_strobes got %b want 01110", stb); end
    checks++; if (mem_writedata !== 8'h00 || zout !== 1'b1 || cout !== 1'b1) begin errors++;
      $display("FAIL add_result got wd=%h z=%b c=%b want 00/1/1", mem_writedata, zout, cout); end
    checks++; if (retired !== 16'd3) begin errors++;
      $display("FAIL add_retired got %0d want 3", retired); end
  endtask

  task automatic test_sub();
    issue(OP_MOVI, 8'h00, 8'h03, 1'b0);
    issue(OP_STORE, 8'h30, 8'h00, 1'b1);
    issue(OP_MOVI, 8'h00, 8'h05, 1'b0);
    issue(OP_SUB, 8'h30, 8'h00, 1'b1);
    checks++; if (stb !== 5'b10110 || mem_writeaddr !== 8'h30) begin errors++;
      $display("FAIL sub_strobes got stb=%b wa=%h want 10110/30", stb, mem_writeaddr); end
    checks++; if (mem_writedata !== 8'hFE || zout !== 1'b0 || cout !== 1'b0) begin errors++;
      $display("FAIL sub_result got wd=%h z=%b c=%b want fe/0/0", mem_writedata, zout, cout); end
    checks++; if (retired !== 16'd7) begin errors++;
      $display("FAIL sub_retired got %0d want 7", retired); end
  endtask

  task automatic test_back_to_back();
    issue(OP_MOVI, 8'h00, 8'h10, 1'b0);
    issue(OP_STORE, 8'h40, 8'h00, 1'b1);
    issue(OP_INC, 8'h40, 8'h00, 1'b1);
    checks++; if (stb !== 5'b10100 || mem_writedata !== 8'h11 || zout !== 1'b0) begin errors++;
      $display("FAIL inc1 got stb=%b wd=%h z=%b want 10100/11/0", stb, mem_writedata, zout); end
    checks++; if (retired !== 16'd10) begin errors++;
      $display("FAIL inc1_retired got %0d want 10", retired); end
    issue(OP_INC, 8'h40, 8'h00, 1'b1);
    checks++; if (mem_write_en !== 1'b1 || mem_writeaddr !== 8'h40 || mem_writedata !== 8'h12)
    begin errors++;
      $display("FAIL inc2 got we=%b wa=%h wd=%h want 1/40/12", mem_write_en, mem_writeaddr,
               mem_writedata); end
    idle();
    checks++; if (retired !== 16'd12) begin errors++;
      $display("FAIL inc_retired got %0d want 12", retired); end
  endtask

  task automatic test_addc();
    issue(OP_MOVI, 8'h00, 8'hFF, 1'b1);
    issue(OP_ADDI, 8'h00, 8'h01, 1'b1);
    checks++; if (stb !== 5'b01110 || mem_writedata !== 8'h00 || zout !== 1'b1 || cout !== 1'b1)
    begin errors++;
      $display("FAIL addi got stb=%b wd=%h z=%b c=%b want 01110/00/1/1", stb, mem_writedata,
               zout, cout); end
    issue(OP_ADDC, 8'h40, 8'h00, 1'b0);
    checks++; if (stb !== 5'b01110 || mem_writedata !== 8'h13 || zout !== 1'b0 || cout !== 1'b0)
    begin errors++;
      $display("FAIL addc got stb=%b wd=%h z=%b c=%b want 01110/13/0/0", stb, mem_writedata,
               zout, cout); end
  endtask

  task automatic test_skip();
    issue(OP_MOVI, 8'h00, 8'h08, 1'b0);
    issue(OP_STORE, 8'h20, 8'h00, 1'b1);
    issue(OP_BTSS, 8'h20, 8'h03, 1'b0);
    checks++; if (stb !== 5'b00001) begin errors++;
      $display("FAIL btss_taken got %b want 00001", stb); end
    checks++; if (retired !== 16'd17) begin errors++;
      $display("FAIL btss_retired got %0d want 17", retired); end
    issue(OP_MOVI, 8'h00, 8'h77, 1'b0);
    checks++; if (stb !== 5'b00000) begin errors++;
      $display("FAIL squashed_movi got %b want 00000", stb); end
    idle();
    checks++; if (retired !== 16'd18) begin errors++;
      $display("FAIL squash_retired got %0d want 18", retired); end
    checks++; if (accum !== 8'h08) begin errors++;
      $display("FAIL squash_accum got %h want 08", accum); end
    issue(OP_BTSC, 8'h20, 8'h03, 1'b0);
    checks++; if (stb !== 5'b00000) begin errors++;
      $display("FAIL btsc_not_taken got %b want 00000", stb); end
    issue(OP_MOVI, 8'h00, 8'h77, 1'b1);
    checks++; if (stb !== 5'b01000 || mem_writedata !== 8'h77) begin errors++;
      $display("FAIL btsc_movi got stb=%b wd=%h want 01000/77", stb, mem_writedata); end
    // Back-to-back skips: the second is squashed and must not squash the MOVI.
    issue(OP_BTSS, 8'h20, 8'h03, 1'b0);
    checks++; if (skip !== 1'b1) begin errors++;
      $display("FAIL btss2_taken got %b want 1", skip); end
    issue(OP_BTSS, 8'h20, 8'h03, 1'b0);
    checks++; if (stb !== 5'b00000) begin errors++;
      $display("FAIL squashed_btss got %b want 00000", stb); end
    issue(OP_MOVI, 8'h00, 8'h55, 1'b0);
    checks++; if (stb !== 5'b01000 || mem_writedata !== 8'h55) begin errors++;
      $display("FAIL post_squash_movi got stb=%b wd=%h want 01000/55", stb, mem_writedata); end
    idle();
    checks++; if (retired !== 16'd22) begin errors++;
      $display("FAIL skip_retired got %0d want 22", retired); end
  endtask

  task automatic test_nop();
    issue(OP_NOP, 8'h55, 8'h00, 1'b1);
    checks++; if (stb !== 5'b00000) begin errors++;
      $display("FAIL nop got %b want 00000", stb); end
    issue(OP_RSVD, 8'h55, 8'h00, 1'b1);
    checks++; if (stb !== 5'b00000) begin errors++;
      $display("FAIL op_f got %b want 00000", stb); end
    idle();
    checks++; if (retired !== 16'd24) begin errors++;
      $display("FAIL nop_retired got %0d want 24", retired); end
  endtask

  task automatic test_reset_mid();
    issue(OP_MOVI, 8'h00, 8'h05, 1'b0);
    issue(OP_ADD, 8'h20, 8'h00, 1'b0);
    reset = 1'b1;
    #1;
    checks++; if (stb !== 5'b00000 || in_ready !== 1'b0) begin errors++;
      $display("FAIL reset_mid got stb=%b rdy=%b want 00000/0", stb, in_ready); end
    in_addr = 8'h00;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++; if (retired !== 16'd0) begin errors++;
      $display("FAIL reset_mid_retired got %0d want 0", retired); end
    checks++; if ({stb, mem_writeaddr, mem_writedata, zout, cout, mem_readaddr} !== 31'd0)
    begin errors++;
      $display("FAIL reset_mid_outputs got stb=%b wa=%h wd=%h z=%b c=%b ra=%h want all 0", stb,
               mem_writeaddr, mem_writedata, zout, cout, mem_readaddr); end
    checks++; if (accum !== 8'h05) begin errors++;
      $display("FAIL reset_mid_accum got %h want 05", accum); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_addc();
    test_skip();
    test_nop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
